xif_offload_initiator: RTL and testbench
========================================

# xif_offload_initiator

Core-side initiator for the struct-based CORE-V-XIF coprocessor protocol. It accepts offload requests (instruction and operands) from a tile-local requester, runs the issue handshake, and drives the mandatory commit (commit or kill) for each issued ID. It tracks outstanding writeback instructions and returns coprocessor results to the requester through a registered buffer. It sits between tile control logic and a struct-side coprocessor such as the FPU subsystem; the compressed, mem and mem_result channels are out of scope.

## Interface
- `ID_WIDTH`, default 4: XIF instruction ID width. IDs wrap modulo 2^ID_WIDTH.
- `MAX_OUTSTANDING`, default 4: maximum number of accepted, not-yet-retired writeback instructions. Must satisfy ≤ 2^ID_WIDTH − 1.
- `NUM_RS`, default 3: number of source operands driven.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_valid_i` / `req_ready_o` in/out 1: requester offload handshake.
- `req_instr_i` in 32: uncompressed instruction.
- `req_rs_i` in NUM_RS×32: operand values. All are treated as valid.
- `x_issue_valid_o` out 1, `x_issue_ready_i` in 1: issue handshake.
- `x_issue_req_o` out `fpu_ss_pkg::x_issue_req_t`: carries instr, mode = M, id, rs, and rs_valid = all ones.
- `x_issue_resp_i` in `fpu_ss_pkg::x_issue_resp_t`: accept, writeback, and related fields.
- `x_commit_valid_o` out 1, `x_commit_o` out `fpu_ss_pkg::x_commit_t`: carries id and commit_kill.
- `x_result_valid_i` in 1, `x_result_ready_o` out 1, `x_result_i` in `fpu_ss_pkg::x_result_t`: result channel.
- `rsp_valid_o` / `rsp_ready_i` out/in 1: response to requester.
- `rsp_id_o` out ID_WIDTH, `rsp_data_o` out 32, `rsp_rd_o` out 5, `rsp_we_o` out 1: response payload.
- `reject_o` out 1, `reject_id_o` out ID_WIDTH: one-cycle pulse when the coprocessor rejects an instruction.
- `busy_o` out 1: high when the FSM is not IDLE or the outstanding count is nonzero.

## Operation
- FSM states:
  - IDLE: req_ready_o = (outstanding < MAX_OUTSTANDING). On the req handshake, register instr, rs and next_id, then go to ISSUE.
  - ISSUE: x_issue_valid_o = 1. The payload stays stable until x_issue_ready_i. On the handshake, latch accept and writeback, then go to COMMIT.
  - COMMIT: x_commit_valid_o = 1 for exactly one cycle. commit.id = issued id; commit_kill = !accept. Go to IDLE.
- next_id increments by one after every issue handshake, whether accepted or rejected, and wraps from 2^ID_WIDTH−1 to 0.
- Rejected instruction: reject_o pulses in the COMMIT cycle with reject_id_o = id. The outstanding count is unchanged.
- Accepted with writeback = 1: outstanding increments in the COMMIT cycle.
- Accepted with writeback = 0: retires at commit; no count change.
- Result handshake (x_result_valid_i && x_result_ready_o): outstanding decrements, and the result is captured into the response buffer.
- Increment and decrement in the same cycle leave the count unchanged.
- A result arriving when outstanding = 0 is a protocol error. An assertion fires; the count saturates at 0.
- Response buffer: 2-entry spill register.
  - x_result_ready_o = buffer not full.
  - The rsp payload comes from the head entry and is held stable while rsp_valid_o && !rsp_ready_i.
- Reset (any cycle, including mid-ISSUE or with results pending): FSM to IDLE, next_id = 0, outstanding = 0, buffer emptied. All valids, reject_o and busy_o go to 0; payload outputs go to 0.

## Timing
- Req handshake at cycle N gives x_issue_valid_o = 1 at N+1 (registered; no combinational path from req to issue).
- Issue handshake at M gives x_commit_valid_o = 1 at M+1 only. req_ready_o can be high again at M+2.
- Best case is one instruction per 3 cycles.
- Result handshake at R gives rsp_valid_o = 1 at R+1. The buffer sustains one result per cycle while rsp_ready_i = 1.
- x_result_ready_o depends only on registered buffer state. No combinational ready-to-valid paths anywhere.
- req_ready_o uses the registered count. A slot freed by a result at cycle R is usable at R+1.

## Structure
- Shared package `xif_offload_pkg` holds:
  - `xif_init_state_e` (IDLE, ISSUE, COMMIT).
  - `xif_rsp_t` (id, data, rd, we).
  - The `MODE_M` constant (2'b11).
- XIF payload types come from `fpu_ss_pkg`.
- Sub-module `xif_result_spill`: 2-entry valid/ready spill register parameterised on `xif_rsp_t`.

## Test plan
- **Single accept with writeback:** req instr = 32'h0000_0053, coprocessor accepts with writeback = 1, result data 32'hDEAD_BEEF arrives 3 cycles later → issue at N+1; commit id 0, kill 0, at M+1; rsp_data_o = 32'hDEAD_BEEF with id 0; outstanding returns to 0.
- **Reject:** accept = 0 → commit_kill = 1; reject_o pulses with id; no rsp; next request uses id+1.
- **Backpressure:** x_issue_ready_i low for 5 cycles → x_issue_valid_o and payload stay stable; then a single commit. rsp_ready_i low with 3 results pending → x_result_ready_o drops after 2 buffered, and no data is lost.
- **Credit limit and simultaneous events:** 4 accepted writeback instructions → req_ready_o = 0. A result retires in the same cycle a COMMIT increments → count unchanged. A result alone → req_ready_o = 1 the next cycle.
- **ID wrap:** 17 issues with ID_WIDTH = 4 → the 17th issue carries id 0.
- **Reset mid-ISSUE with 2 outstanding:** rst_i = 1 for 1 cycle → all outputs 0 the next cycle, id restarts at 0, busy_o = 0.

Source files
------------

// File: rtl/fpu_ss_pkg.sv
// XIF payload types shared with the struct-side coprocessor (FPU subsystem).
// Only the issue, commit and result channels are described here.
package fpu_ss_pkg;

  localparam int unsigned X_NUM_RS    = 3;
  localparam int unsigned X_ID_WIDTH  = 4;
  localparam int unsigned X_RFR_WIDTH = 32;
  localparam int unsigned X_RFW_WIDTH = 32;

  typedef struct packed {
    logic [31:0]                          instr;
    logic [1:0]                           mode;
    logic [X_ID_WIDTH-1:0]                id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs;
    logic [X_NUM_RS-1:0]                  rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic float;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   float;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

endpackage

// File: rtl/xif_offload_initiator_pkg.sv
// Types and constants shared by the XIF offload initiator and its buffer.
package xif_offload_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    COMMIT = 2'd2
  } xif_init_state_e;

  // One buffered coprocessor result as returned to the requester.
  typedef struct packed {
    logic [fpu_ss_pkg::X_ID_WIDTH-1:0] id;
    logic [31:0]                       data;
    logic [4:0]                        rd;
    logic                              we;
  } xif_rsp_t;

  // Privilege mode carried with every issued instruction (machine mode).
  localparam logic [1:0] MODE_M = 2'b11;

endpackage

// File: rtl/xif_offload_initiator_if.sv
// Coprocessor-side XIF channels (issue, commit, result) of the initiator.
// The master modport is the core/initiator side, slave the coprocessor.
interface xif_offload_initiator_if;

  logic                      x_issue_valid;
  logic                      x_issue_ready;
  fpu_ss_pkg::x_issue_req_t  x_issue_req;
  fpu_ss_pkg::x_issue_resp_t x_issue_resp;

  logic                      x_commit_valid;
  fpu_ss_pkg::x_commit_t     x_commit;

  logic                      x_result_valid;
  logic                      x_result_ready;
  fpu_ss_pkg::x_result_t     x_result;

  modport master (
    output x_issue_valid,
    output x_issue_req,
    input  x_issue_ready,
    input  x_issue_resp,
    output x_commit_valid,
    output x_commit,
    input  x_result_valid,
    input  x_result,
    output x_result_ready
  );

  modport slave (
    input  x_issue_valid,
    input  x_issue_req,
    output x_issue_ready,
    output x_issue_resp,
    input  x_commit_valid,
    input  x_commit,
    output x_result_valid,
    output x_result,
    input  x_result_ready
  );

endinterface

// File: rtl/xif_offload_initiator_chk.sv
// Protocol checks for the offload initiator.
module xif_offload_initiator_chk #(
  parameter int unsigned REQ_W = 8
) (
  input logic             clk_i,
  input logic             rst_i,
  input logic             result_hs_i,
  input logic             cnt_zero_i,
  input logic             commit_valid_i,
  input logic             issue_valid_i,
  input logic             issue_ready_i,
  input logic [REQ_W-1:0] issue_req_i
);

  // A result must never arrive with nothing outstanding.
  a_result_when_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    !(result_hs_i && cnt_zero_i));

  // Commit is a single-cycle pulse per issued instruction.
  a_commit_single: assert property (@(posedge clk_i) disable iff (rst_i)
    commit_valid_i |=> !commit_valid_i);

  // The issue payload is held until the coprocessor takes it.
  a_issue_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (!rst_i && issue_valid_i && !issue_ready_i) |=> (issue_valid_i && $stable(issue_req_i)));

endmodule

// File: rtl/xif_result_spill.sv
// Two-entry valid/ready spill register. Entry A is always the head; entry B
// only holds data while A is occupied. Ready is a pure function of the
// registered occupancy, so there is no combinational path from out_ready_i.
module xif_result_spill
  import xif_offload_pkg::*;
#(
  parameter type T = xif_rsp_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  logic a_vld_q, a_vld_d;
  logic b_vld_q, b_vld_d;
  T     a_q, a_d;
  T     b_q, b_d;
  logic push_s;
  logic pop_s;

  assign in_ready_o  = !(a_vld_q && b_vld_q);
  assign push_s      = in_valid_i && in_ready_o;
  assign pop_s       = a_vld_q && out_ready_i;
  assign out_valid_o = a_vld_q;
  assign out_data_o  = a_q;

  // Entry movement for push, pop or both in the same cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    a_vld_d = a_vld_q;
    b_vld_d = b_vld_q;
    case ({push_s, pop_s})
      2'b10: begin
        if (!a_vld_q) begin
          a_d     = in_data_i;
          a_vld_d = 1'b1;
        end else begin
          b_d     = in_data_i;
          b_vld_d = 1'b1;
        end
      end
      2'b01: begin
        if (b_vld_q) begin
          a_d = b_q;
        end else begin
          a_d = a_q;
        end
        a_vld_d = b_vld_q;
        b_vld_d = 1'b0;
      end
      2'b11: begin
        if (b_vld_q) begin
          a_d = b_q;
          b_d = in_data_i;
        end else begin
          a_d = in_data_i;
        end
      end
      default: begin
        a_d = a_q;
      end
    endcase
  end

  // Buffer storage and occupancy flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      a_vld_q <= a_vld_d;
      b_vld_q <= b_vld_d;
    end
  end

endmodule

// File: rtl/xif_offload_initiator.sv
// Core-side CORE-V-XIF initiator: takes offload requests, runs the issue
// handshake, commits or kills every issued ID, credits outstanding
// writeback instructions and returns results through a spill buffer.
module xif_offload_initiator
  import fpu_ss_pkg::*;
  import xif_offload_pkg::*;
#(
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned NUM_RS          = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [31:0]              req_instr_i,
  input  logic [NUM_RS-1:0][31:0]  req_rs_i,
  xif_offload_initiator_if.master  xif,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ID_WIDTH-1:0]      rsp_id_o,
  output logic [31:0]              rsp_data_o,
  output logic [4:0]               rsp_rd_o,
  output logic                     rsp_we_o,
  output logic                     reject_o,
  output logic [ID_WIDTH-1:0]      reject_id_o,
  output logic                     busy_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  xif_init_state_e            state_q, state_d;
  logic [31:0]                instr_q, instr_d;
  logic [NUM_RS-1:0][31:0]    rs_q, rs_d;
  logic [ID_WIDTH-1:0]        id_q, id_d;
  logic [ID_WIDTH-1:0]        next_id_q, next_id_d;
  logic                       accept_q, accept_d;
  logic                       wb_q, wb_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic                       req_ready_s;
  logic                       issue_valid_s;
  logic                       commit_valid_s;
  logic                       cnt_inc_s;
  logic                       cnt_dec_s;
  logic                       result_hs_s;
  logic                       res_ready_s;
  logic [X_NUM_RS-1:0][31:0]  rs_map_s;
  x_issue_req_t               issue_req_s;
  x_commit_t                  commit_s;
  xif_rsp_t                   res_in_s;
  xif_rsp_t                   rsp_head_s;
  logic                       unused_s;

  // Coprocessor response fields that this initiator does not act on.
  assign unused_s = ^{xif.x_issue_resp, xif.x_result};

  // Operand slots beyond NUM_RS are driven as zero.
  for (genvar g = 0; g < X_NUM_RS; g++) begin : g_rs
    if (g < NUM_RS) begin : g_used
      assign rs_map_s[g] = rs_q[g];
    end else begin : g_zero
      assign rs_map_s[g] = 32'h0000_0000;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched request, issued id, issue response and outstanding credit count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q   <= 32'h0000_0000;
      rs_q      <= '0;
      id_q      <= '0;
      next_id_q <= '0;
      accept_q  <= 1'b0;
      wb_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      instr_q   <= instr_d;
      rs_q      <= rs_d;
      id_q      <= id_d;
      next_id_q <= next_id_d;
      accept_q  <= accept_d;
      wb_q      <= wb_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic and handshake decode for IDLE -> ISSUE -> COMMIT.
  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    rs_d           = rs_q;
    id_d           = id_q;
    next_id_d      = next_id_q;
    accept_d       = accept_q;
    wb_d           = wb_q;
    req_ready_s    = 1'b0;
    issue_valid_s  = 1'b0;
    commit_valid_s = 1'b0;
    cnt_inc_s      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_s = (cnt_q < CNT_W'(MAX_OUTSTANDING));
        if (req_valid_i && req_ready_s) begin
          instr_d = req_instr_i;
          rs_d    = req_rs_i;
          id_d    = next_id_q;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        issue_valid_s = 1'b1;
        if (xif.x_issue_ready) begin
          accept_d  = xif.x_issue_resp.accept;
          wb_d      = xif.x_issue_resp.writeback;
          // IDs advance on every issue, rejected ones included.
          next_id_d = next_id_q + ID_WIDTH'(1);
          state_d   = COMMIT;
        end else begin
          state_d = ISSUE;
        end
      end
      COMMIT: begin
        commit_valid_s = 1'b1;
        cnt_inc_s      = accept_q && wb_q;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outstanding count: commit credits, result retires, saturating at zero.
  always_comb begin
    result_hs_s = xif.x_result_valid && res_ready_s;
    cnt_dec_s   = result_hs_s && (cnt_q != '0);
    case ({cnt_inc_s, cnt_dec_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Issue and commit payloads, forced to zero outside their own state.
  always_comb begin
    issue_req_s = '0;
    commit_s    = '0;
    if (state_q == ISSUE) begin
      issue_req_s.instr    = instr_q;
      issue_req_s.mode     = MODE_M;
      issue_req_s.id       = X_ID_WIDTH'(id_q);
      issue_req_s.rs       = rs_map_s;
      issue_req_s.rs_valid = {X_NUM_RS{1'b1}};
    end else begin
      issue_req_s = '0;
    end
    if (state_q == COMMIT) begin
      commit_s.id          = X_ID_WIDTH'(id_q);
      commit_s.commit_kill = !accept_q;
    end else begin
      commit_s = '0;
    end
  end

  assign req_ready_o        = req_ready_s;
  assign xif.x_issue_valid  = issue_valid_s;
  assign xif.x_issue_req    = issue_req_s;
  assign xif.x_commit_valid = commit_valid_s;
  assign xif.x_commit       = commit_s;
  assign xif.x_result_ready = res_ready_s;
  assign reject_o           = commit_valid_s && !accept_q;
  assign reject_id_o        = (commit_valid_s && !accept_q) ? id_q : '0;
  assign busy_o             = (state_q != IDLE) || (cnt_q != '0);

  assign res_in_s = '{id:   xif.x_result.id,
                      data: xif.x_result.data,
                      rd:   xif.x_result.rd,
                      we:   xif.x_result.we};

  xif_result_spill #(
    .T (xif_rsp_t)
  ) u_spill (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (xif.x_result_valid),
    .in_ready_o  (res_ready_s),
    .in_data_i   (res_in_s),
    .out_valid_o (rsp_valid_o),
    .out_ready_i (rsp_ready_i),
    .out_data_o  (rsp_head_s)
  );

  assign rsp_id_o   = ID_WIDTH'(rsp_head_s.id);
  assign rsp_data_o = rsp_head_s.data;
  assign rsp_rd_o   = rsp_head_s.rd;
  assign rsp_we_o   = rsp_head_s.we;

  xif_offload_initiator_chk #(
    .REQ_W ($bits(x_issue_req_t))
  ) u_chk (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .result_hs_i    (result_hs_s),
    .cnt_zero_i     (cnt_q == '0),
    .commit_valid_i (commit_valid_s),
    .issue_valid_i  (issue_valid_s),
    .issue_ready_i  (xif.x_issue_ready),
    .issue_req_i    (issue_req_s)
  );

endmodule

// File: tb/tb_xif_offload_initiator.sv
// Scoreboard bench for xif_offload_initiator: stimulus pushes expected
// issue/commit/reject/response entries, a negedge monitor pops and compares.
module tb_xif_offload_initiator;
  import fpu_ss_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i;
  logic             req_valid, req_ready;
  logic [31:0]      req_instr;
  logic [2:0][31:0] req_rs;
  logic             rsp_valid, rsp_ready;
  logic [3:0]       rsp_id;
  logic [31:0]      rsp_data;
  logic [4:0]       rsp_rd;
  logic             rsp_we;
  logic             reject;
  logic [3:0]       reject_id;
  logic             busy;

  xif_offload_initiator_if xif_if();

  xif_offload_initiator #(
    .ID_WIDTH(4), .MAX_OUTSTANDING(4), .NUM_RS(3)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_instr_i(req_instr), .req_rs_i(req_rs),
    .xif(xif_if.master),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .rsp_rd_o(rsp_rd), .rsp_we_o(rsp_we),
    .reject_o(reject), .reject_id_o(reject_id), .busy_o(busy)
  );

  localparam logic [31:0] RS1 = 32'hA5A5_0001;
  localparam logic [31:0] RS2 = 32'h5A5A_0002;

  typedef struct { logic [31:0] instr; logic [3:0] id; logic [31:0] rs0; } iss_e_t;
  typedef struct { logic [3:0] id; logic kill; } cmt_e_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [4:0] rd; logic we; } rsp_e_t;

  iss_e_t     iss_q[$];
  cmt_e_t     cmt_q[$];
  logic [3:0] rej_q[$];
  rsp_e_t     rsp_q[$];

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_id;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=output_present expected=none_pending", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every DUT output event is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (xif_if.x_issue_valid && xif_if.x_issue_ready) begin
        if (iss_q.size() == 0) unexpected("issue_unexp");
        else begin
          iss_e_t e;
          e = iss_q.pop_front();
          check("issue_instr", xif_if.x_issue_req.instr, e.instr);
          check("issue_id", xif_if.x_issue_req.id, e.id);
          check("issue_mode", xif_if.x_issue_req.mode, 2'b11);
          check("issue_rs0", xif_if.x_issue_req.rs[0], e.rs0);
          check("issue_rs1", xif_if.x_issue_req.rs[1], RS1);
          check("issue_rs2", xif_if.x_issue_req.rs[2], RS2);
          check("issue_rs_valid", xif_if.x_issue_req.rs_valid, 3'b111);
        end
      end
      if (xif_if.x_commit_valid) begin
        if (cmt_q.size() == 0) unexpected("commit_unexp");
        else begin
          cmt_e_t c;
          c = cmt_q.pop_front();
          check("commit_id", xif_if.x_commit.id, c.id);
          check("commit_kill", xif_if.x_commit.commit_kill, c.kill);
        end
      end
      if (reject) begin
        if (rej_q.size() == 0) unexpected("reject_unexp");
        else check("reject_id", reject_id, rej_q.pop_front());
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) unexpected("rsp_unexp");
        else begin
          rsp_e_t r;
          r = rsp_q.pop_front();
          check("rsp_id", rsp_id, r.id);
          check("rsp_data", rsp_data, r.data);
          check("rsp_rd", rsp_rd, r.rd);
          check("rsp_we", rsp_we, r.we);
        end
      end
    end
  end

  // One full offload: request, optional issue backpressure, commit.
  task automatic offload(input logic [31:0] instr, input logic acc, input logic wb, input int delay);
    logic [$bits(x_issue_req_t)-1:0] snap;
    iss_e_t ie;
    cmt_e_t ce;
    int n;
    ie.instr = instr; ie.id = exp_id; ie.rs0 = instr ^ 32'hFFFF_0000;
    ce.id = exp_id; ce.kill = !acc;
    iss_q.push_back(ie);
    cmt_q.push_back(ce);
    if (!acc) rej_q.push_back(exp_id);
    req_valid = 1'b1;
    req_instr = instr;
    req_rs    = {RS2, RS1, instr ^ 32'hFFFF_0000};
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    check("req_ready_wait", n < 100, 1'b1);
    tick();
    req_valid = 1'b0;
    check("issue_valid_n1", xif_if.x_issue_valid, 1'b1);
    snap = xif_if.x_issue_req;
    repeat (delay) begin
      tick();
      check("issue_hold_valid", xif_if.x_issue_valid, 1'b1);
      check("issue_hold_payload", snap == xif_if.x_issue_req, 1'b1);
      check("commit_early", xif_if.x_commit_valid, 1'b0);
    end
    xif_if.x_issue_ready = 1'b1;
    xif_if.x_issue_resp = '0;
    xif_if.x_issue_resp.accept = acc;
    xif_if.x_issue_resp.writeback = wb;
    tick();
    xif_if.x_issue_ready = 1'b0;
    xif_if.x_issue_resp = '0;
    check("commit_m1", xif_if.x_commit_valid, 1'b1);
    check("reject_at_commit", reject, !acc);
    exp_id = exp_id + 4'd1;
    tick();
    check("commit_once", xif_if.x_commit_valid, 1'b0);
    check("reject_once", reject, 1'b0);
  endtask

  // One coprocessor result, waiting for buffer space.
  task automatic send_result(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd);
    rsp_e_t re;
    int n;
    re.id = id; re.data = data; re.rd = rd; re.we = 1'b1;
    rsp_q.push_back(re);
    xif_if.x_result_valid = 1'b1;
    xif_if.x_result = '0;
    xif_if.x_result.id = id;
    xif_if.x_result.data = data;
    xif_if.x_result.rd = rd;
    xif_if.x_result.we = 1'b1;
    n = 0;
    while (!xif_if.x_result_ready && n < 100) begin
      tick();
      n++;
    end
    check("result_ready_wait", n < 100, 1'b1);
    tick();
    xif_if.x_result_valid = 1'b0;
    xif_if.x_result = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    req_valid = 1'b0; req_instr = 32'h0; req_rs = '0;
    rsp_ready = 1'b1;
    xif_if.x_issue_ready = 1'b0; xif_if.x_issue_resp = '0;
    xif_if.x_result_valid = 1'b0; xif_if.x_result = '0;
    exp_id = 4'd0;
    repeat (3) tick();
    check("rst_issue_valid", xif_if.x_issue_valid, 1'b0);
    check("rst_commit_valid", xif_if.x_commit_valid, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_reject", reject, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result_ready", xif_if.x_result_ready, 1'b1);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_data", rsp_data, 32'h0);
    rst_i = 1'b0;
    tick();

    // Single accept with writeback, result three cycles later.
    offload(32'h0000_0053, 1'b1, 1'b1, 0);
    check("busy_outstanding", busy, 1'b1);
    repeat (3) tick();
    send_result(4'd0, 32'hDEAD_BEEF, 5'd10);
    check("rsp_valid_r1", rsp_valid, 1'b1);
    check("rsp_data_r1", rsp_data, 32'hDEAD_BEEF);
    check("busy_after_result", busy, 1'b0);

    // Reject, then accepted without writeback.
    offload(32'h1000_0053, 1'b0, 1'b1, 0);
    check("busy_after_reject", busy, 1'b0);
    offload(32'h2000_0053, 1'b1, 1'b0, 0);
    check("busy_after_nowb", busy, 1'b0);

    // Issue backpressure for 5 cycles.
    offload(32'h3000_0053, 1'b1, 1'b0, 5);

    // Response backpressure with three results.
    offload(32'h4000_0053, 1'b1, 1'b1, 0);
    offload(32'h5000_0053, 1'b1, 1'b1, 0);
    offload(32'h6000_0053, 1'b1, 1'b1, 0);
    rsp_ready = 1'b0;
    send_result(4'd4, 32'h1111_0004, 5'd4);
    send_result(4'd5, 32'h1111_0005, 5'd5);
    check("result_ready_full", xif_if.x_result_ready, 1'b0);
    check("rsp_hold_id", rsp_id, 4'd4);
    tick();
    check("rsp_hold_valid", rsp_valid, 1'b1);
    check("rsp_hold_data", rsp_data, 32'h1111_0004);
    rsp_ready = 1'b1;
    send_result(4'd6, 32'h1111_0006, 5'd6);
    repeat (3) tick();
    check("busy_drained", busy, 1'b0);

    // Credit limit and simultaneous increment/decrement.
    offload(32'h7000_0053, 1'b1, 1'b1, 0);
    offload(32'h8000_0053, 1'b1, 1'b1, 0);
    offload(32'h9000_0053, 1'b1, 1'b1, 0);
    offload(32'hA000_0053, 1'b1, 1'b1, 0);
    check("req_ready_at_limit", req_ready, 1'b0);
    send_result(4'd7, 32'h2222_0007, 5'd7);
    check("req_ready_slot_freed", req_ready, 1'b1);
    fork
      offload(32'hB000_0053, 1'b1, 1'b1, 0);
      begin
        tick();
        tick();
        send_result(4'd8, 32'h2222_0008, 5'd8);
      end
    join
    check("req_ready_after_simul", req_ready, 1'b1);
    offload(32'hC000_0053, 1'b1, 1'b1, 0);
    check("req_ready_limit_again", req_ready, 1'b0);
    send_result(4'd9,  32'h2222_0009, 5'd9);
    send_result(4'd10, 32'h2222_000A, 5'd11);
    send_result(4'd11, 32'h2222_000B, 5'd12);
    send_result(4'd12, 32'h2222_000C, 5'd13);
    repeat (3) tick();
    check("busy_credit_drained", busy, 1'b0);

    // ID wrap: ids 13, 14, 15, then the 17th issue carries id 0.
    offload(32'hD000_0053, 1'b0, 1'b0, 0);
    offload(32'hE000_0053, 1'b1, 1'b0, 0);
    offload(32'hF000_0053, 1'b0, 1'b1, 0);
    offload(32'h0100_0053, 1'b1, 1'b0, 0);

    // Reset mid-ISSUE with two outstanding.
    offload(32'h0200_0053, 1'b1, 1'b1, 0);
    offload(32'h0300_0053, 1'b1, 1'b1, 0);
    req_valid = 1'b1;
    req_instr = 32'h0400_0053;
    req_rs    = {RS2, RS1, 32'h0400_0053 ^ 32'hFFFF_0000};
    tick();
    req_valid = 1'b0;
    check("issue_before_rst", xif_if.x_issue_valid, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mid_rst_issue_valid", xif_if.x_issue_valid, 1'b0);
    check("mid_rst_issue_payload", xif_if.x_issue_req == '0, 1'b1);
    check("mid_rst_commit_valid", xif_if.x_commit_valid, 1'b0);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_reject", reject, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rsp_data", rsp_data, 32'h0);
    exp_id = 4'd0;
    offload(32'h0500_0053, 1'b1, 1'b0, 0);
    check("busy_end", busy, 1'b0);

    repeat (3) tick();
    check("iss_q_empty", iss_q.size(), 0);
    check("cmt_q_empty", cmt_q.size(), 0);
    check("rej_q_empty", rej_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
